// File: rtl/heartbeat_pkg.sv
// heartbeat_pkg
// Shared definitions for the heartbeat monitor:
//   hb_state_t  - monitor state encoding (IDLE, LOCKING, LOCKED, LOST)
//   hb_period   - expected heartbeat interval P = 2^N
//   hb_win_lo   - earliest accepted interval, P - TOL
//   hb_win_hi   - latest accepted interval, P + TOL (also the timeout point)
package heartbeat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } hb_state_t;

    function automatic int hb_period(input int n);
        return 1 << n;
    endfunction

    function automatic int hb_win_lo(input int n, input int tol);
        return (1 << n) - tol;
    endfunction

    function automatic int hb_win_hi(input int n, input int tol);
        return (1 << n) + tol;
    endfunction

endpackage

// File: rtl/heartbeat_window.sv
// heartbeat_window
// Rising-edge detector, saturating interval counter and window compare.
// Ports:
//   clk, nreset  - clock, asynchronous active-low reset
//   hb_in        - heartbeat input (rising edges count)
//   arm          - enables timeout detection (monitor not in IDLE)
//   rise         - rising edge of hb_in in this cycle
//   interval     - cnt+1 saturated to N+1 bits (interval if rise is set)
//   good         - rise with interval inside [P-TOL, P+TOL]
//   early        - rise with interval below P-TOL
//   timeout      - armed, no rise, and interval reached P+TOL
module heartbeat_window
    import heartbeat_pkg::*;
#(
    parameter int N   = 8,
    parameter int TOL = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       hb_in,
    input  logic       arm,
    output logic       rise,
    output logic [N:0] interval,
    output logic       good,
    output logic       early,
    output logic       timeout
);

    localparam logic [N:0] WIN_LO_C = (N+1)'(hb_win_lo(N, TOL));
    localparam logic [N:0] WIN_HI_C = (N+1)'(hb_win_hi(N, TOL));
    localparam logic [N:0] CNT_MAX  = '1;

    logic       hb_q;
    logic [N:0] cnt;

    always_comb begin
        rise     = hb_in & ~hb_q;
        // Saturating cnt+1 doubles as the next counter value when not cleared.
        interval = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
        good     = rise & (interval >= WIN_LO_C) & (interval <= WIN_HI_C);
        early    = rise & (interval < WIN_LO_C);
        // An edge landing exactly on the window close wins over the timeout.
        timeout  = arm & ~rise & (interval == WIN_HI_C);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hb_q <= 1'b0;
            cnt  <= '0;
        end else begin
            hb_q <= hb_in;
            if (rise || timeout) begin
                cnt <= '0;
            end else begin
                cnt <= interval;
            end
        end
    end

endmodule

// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor
// Checks a heartbeat pulse train: locks when edges arrive every 2^N +/- TOL
// cycles, flags early edges and missed windows, and declares loss after
// MISS_MAX consecutive missed windows.
// Ports:
//   clk, nreset  - clock, asynchronous active-low reset
//   hb_in        - heartbeat input (rising edges count)
//   locked       - level, periodic heartbeat confirmed
//   lost         - level, MISS_MAX consecutive windows missed
//   early_err    - one-cycle pulse, edge before P-TOL
//   miss_err     - one-cycle pulse, window closed with no edge
//   last_period  - interval measured at the most recent edge
//   edge_count   - rising edges seen, wraps modulo 2^CW
// The FSM state is available as the internal signal 'state' for probing.
module heartbeat_monitor
    import heartbeat_pkg::*;
#(
    parameter int N        = 8,
    parameter int TOL      = 2,
    parameter int MISS_MAX = 3,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          hb_in,
    output logic          locked,
    output logic          lost,
    output logic          early_err,
    output logic          miss_err,
    output logic [N:0]    last_period,
    output logic [CW-1:0] edge_count
);

    localparam int              MRW    = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);
    localparam logic [MRW-1:0]  MR_MAX = MRW'(MISS_MAX);

    hb_state_t      state;
    logic [MRW-1:0] miss_run;
    logic [MRW-1:0] miss_run_inc;

    logic           arm;
    logic           rise;
    logic [N:0]     interval;
    logic           good;
    logic           early;
    logic           timeout;

    assign arm          = (state != IDLE);
    assign miss_run_inc = (miss_run == MR_MAX) ? MR_MAX : miss_run + 1'b1;

    heartbeat_window #(
        .N   (N),
        .TOL (TOL)
    ) u_window (
        .clk      (clk),
        .nreset   (nreset),
        .hb_in    (hb_in),
        .arm      (arm),
        .rise     (rise),
        .interval (interval),
        .good     (good),
        .early    (early),
        .timeout  (timeout)
    );

    // locked/lost are registered alongside state so they always equal
    // (state == LOCKED) / (state == LOST) without a decode after the flops.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            locked      <= 1'b0;
            lost        <= 1'b0;
            early_err   <= 1'b0;
            miss_err    <= 1'b0;
            last_period <= '0;
            edge_count  <= '0;
            miss_run    <= '0;
        end else begin
            early_err <= 1'b0;
            miss_err  <= 1'b0;

            if (rise) begin
                edge_count <= edge_count + 1'b1;
                miss_run   <= '0;
                // The first edge after IDLE has no meaningful interval.
                if (state != IDLE) begin
                    last_period <= interval;
                end
                case (state)
                    IDLE: begin
                        state  <= LOCKING;
                        locked <= 1'b0;
                        lost   <= 1'b0;
                    end
                    LOCKING: begin
                        if (good) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            early_err <= early;
                        end
                    end
                    LOCKED: begin
                        if (!good) begin
                            state     <= LOCKING;
                            locked    <= 1'b0;
                            early_err <= early;
                        end
                    end
                    LOST: begin
                        state     <= LOCKING;
                        locked    <= 1'b0;
                        lost      <= 1'b0;
                        early_err <= early;
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        lost   <= 1'b0;
                    end
                endcase
            end else if (timeout) begin
                miss_err <= 1'b1;
                miss_run <= miss_run_inc;
                if (miss_run_inc == MR_MAX) begin
                    state  <= LOST;
                    locked <= 1'b0;
                    lost   <= 1'b1;
                end else if (state == LOCKED) begin
                    state  <= LOCKING;
                    locked <= 1'b0;
                end
            end
        end
    end

endmodule
